// File: rtl/heap_sort_pkg.sv
// heap_sort_pkg
//   Shared definitions for the heap sort sequencer and its neighbours.
//   - DEF_KEY_W / DEF_DEPTH : default key width and heap capacity
//   - HQ_PUSH / HQ_POP      : encoding of the hq_cmd_push command bit
//   - seq_state_t           : sequencer FSM states
package heap_sort_pkg;

  localparam int DEF_KEY_W = 32;
  localparam int DEF_DEPTH = 16;

  localparam logic HQ_PUSH = 1'b1;
  localparam logic HQ_POP  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    POP,
    WAIT,
    OUT
  } seq_state_t;

endpackage

// File: rtl/heap_sort_sequencer.sv
// heap_sort_sequencer
//   Drives the heap priority queue through one sort batch: every incoming key
//   is pushed into the heap, then the heap is popped empty and the keys are
//   streamed out in ascending order.
//
// Ports
//   system1000, system1000_rst         : clock and synchronous active-high reset
//   in_valid/in_ready/in_key/in_last   : producer key stream
//   out_valid/out_ready/out_key/out_last : sorted key stream (registered)
//   hq_cmd_valid/hq_cmd_push/hq_cmd_key/hq_cmd_ready : heap command channel
//   hq_rsp_valid/hq_rsp_key            : heap pop result (one-cycle pulse)
//   busy      : FSM is outside IDLE
//   count     : keys currently held in the heap
//   overflow  : sticky, a batch ran into the heap capacity without in_last
//   order_err : sticky, a popped key was below its predecessor
module heap_sort_sequencer
  import heap_sort_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic             out_last,
  output logic             hq_cmd_valid,
  output logic             hq_cmd_push,
  output logic [KEY_W-1:0] hq_cmd_key,
  input  logic             hq_cmd_ready,
  input  logic             hq_rsp_valid,
  input  logic [KEY_W-1:0] hq_rsp_key,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             order_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  seq_state_t state, state_nxt;

  logic [CNT_W-1:0] count_q;
  logic [KEY_W-1:0] out_key_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [KEY_W-1:0] prev_key_q;
  logic             prev_valid_q;
  logic             overflow_q;
  logic             order_err_q;

  logic has_room;
  logic push_fire;
  logic fills_heap;
  logic rsp_take;
  logic out_fire;
  logic last_out;

  assign has_room   = (count_q < DEPTH_C);
  assign fills_heap = (count_q == DEPTH_C - ONE_C);
  assign last_out   = (count_q == ONE_C);
  assign push_fire  = ((state == IDLE) || (state == FILL)) && in_valid && in_ready;
  assign rsp_take   = (state == WAIT) && hq_rsp_valid;
  assign out_fire   = (state == OUT) && out_ready;

  // The push operand is always the producer key; the heap ignores it on pops.
  assign hq_cmd_key = in_key;
  assign busy       = (state != IDLE);
  assign count      = count_q;
  assign out_valid  = out_valid_q;
  assign out_key    = out_key_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign order_err  = order_err_q;

  // State register. Reset abandons any batch in flight; the heap shares the
  // same reset, so nothing needs to be flushed.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and command decode. While filling, the producer handshake is
  // passed straight through to the heap so pushes cost no extra cycle. The
  // batch closes on in_last or on the push that fills the heap, whichever
  // comes first; from then on the producer is stalled until the batch drains.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    hq_cmd_valid = 1'b0;
    hq_cmd_push  = HQ_PUSH;
    case (state)
      IDLE, FILL: begin
        hq_cmd_valid = in_valid & has_room;
        in_ready     = hq_cmd_ready & has_room;
        if (in_valid && in_ready) begin
          if (in_last || fills_heap) begin
            state_nxt = POP;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      POP: begin
        hq_cmd_valid = 1'b1;
        hq_cmd_push  = HQ_POP;
        if (hq_cmd_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (hq_rsp_valid) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = last_out ? IDLE : POP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy, output register, previous-key tracker and sticky flags.
  // Responses are only taken in WAIT, so stray pulses elsewhere are dropped.
  // The previous-key tracker is cleared when the batch drains, so the first
  // key of the next batch is never compared against the last of this one.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      count_q      <= '0;
      out_key_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      prev_key_q   <= '0;
      prev_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      order_err_q  <= 1'b0;
    end else begin
      if (push_fire) begin
        count_q <= count_q + ONE_C;
        if (fills_heap && !in_last) begin
          overflow_q <= 1'b1;
        end
      end
      if (rsp_take) begin
        out_key_q    <= hq_rsp_key;
        out_valid_q  <= 1'b1;
        out_last_q   <= last_out;
        prev_key_q   <= hq_rsp_key;
        prev_valid_q <= 1'b1;
        if (prev_valid_q && (hq_rsp_key < prev_key_q)) begin
          order_err_q <= 1'b1;
        end
      end
      if (out_fire) begin
        out_valid_q <= 1'b0;
        count_q     <= count_q - ONE_C;
        if (last_out) begin
          prev_valid_q <= 1'b0;
          prev_key_q   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_heap_sort_sequencer.sv
// tb_heap_sort_sequencer
//   Directed bench for heap_sort_sequencer. A behavioural heap (unsorted queue,
//   minimum taken on pop, response after rsp_lat cycles) answers the command
//   channel; expected sorted sequences are written out by hand below.
module tb_heap_sort_sequencer;
  import heap_sort_pkg::*;

  localparam int KW = 32;
  localparam int DP = 16;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] in_key = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [KW-1:0] out_key;
  logic          out_last;
  logic          hq_cmd_valid;
  logic          hq_cmd_push;
  logic [KW-1:0] hq_cmd_key;
  logic          hq_cmd_ready = 1'b1;
  logic          hq_rsp_valid = 1'b0;
  logic [KW-1:0] hq_rsp_key = '0;
  logic          busy;
  logic [CW-1:0] count;
  logic          overflow;
  logic          order_err;

  int n_cmp = 0;
  int n_mis = 0;

  // Controls written only by the stimulus block
  int          rsp_lat = 2;
  int          force_n = 0;
  logic [KW-1:0] force_key [2];
  int          stray_req = 0;

  // State owned only by the heap model
  logic [KW-1:0] heap_q[$];
  int            pend = 0;
  logic [KW-1:0] pend_key = '0;
  int            force_used = 0;
  int            stray_done = 0;
  int            push_cnt = 0;
  int            pop_cnt = 0;
  int            mdl_mi;

  heap_sort_sequencer #(.KEY_W(KW), .DEPTH(DP)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_key         (in_key),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_key        (out_key),
    .out_last       (out_last),
    .hq_cmd_valid   (hq_cmd_valid),
    .hq_cmd_push    (hq_cmd_push),
    .hq_cmd_key     (hq_cmd_key),
    .hq_cmd_ready   (hq_cmd_ready),
    .hq_rsp_valid   (hq_rsp_valid),
    .hq_rsp_key     (hq_rsp_key),
    .busy           (busy),
    .count          (count),
    .overflow       (overflow),
    .order_err      (order_err)
  );

  always #5 clk = ~clk;

  // Heap model. It looks at the command channel on the falling edge, where
  // everything it sees is what the DUT will sample on the next rising edge,
  // and raises its response so that it is sampled rsp_lat edges after the
  // command handshake.
  always @(negedge clk) begin
    if (rst) begin
      heap_q.delete();
      pend = 0;
      hq_rsp_valid = 1'b0;
    end else begin
      hq_rsp_valid = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          hq_rsp_valid = 1'b1;
          hq_rsp_key   = pend_key;
        end
      end
      if (stray_req != stray_done) begin
        stray_done   = stray_req;
        hq_rsp_valid = 1'b1;
        hq_rsp_key   = 32'd99;
      end
      if (hq_cmd_valid && hq_cmd_ready) begin
        if (hq_cmd_push) begin
          heap_q.push_back(hq_cmd_key);
          push_cnt = push_cnt + 1;
        end else begin
          pend_key = 32'hDEAD_BEEF;
          if (heap_q.size() > 0) begin
            mdl_mi = 0;
            for (int i = 1; i < heap_q.size(); i++) begin
              if (heap_q[i] < heap_q[mdl_mi]) mdl_mi = i;
            end
            pend_key = heap_q[mdl_mi];
            heap_q.delete(mdl_mi);
          end
          if (force_used < force_n) begin
            pend_key   = force_key[force_used];
            force_used = force_used + 1;
          end
          pend    = rsp_lat;
          pop_cnt = pop_cnt + 1;
        end
      end
    end
  end

  // Absolute time bound so a stuck handshake can never hang the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one key and wait (bounded) for the handshake edge
  task automatic applyStimulus(input logic [KW-1:0] key, input logic last);
    int n;
    in_valid = 1'b1;
    in_key   = key;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("in_handshake", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  // Wait (bounded) for a sorted key, capture it, then complete the handshake
  task automatic getOutput(output logic [KW-1:0] key, output logic last, output int waited);
    waited = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("out_arrive", {31'd0, out_valid}, 32'd1);
    key  = out_key;
    last = out_last;
    tick();
  endtask

  initial begin
    logic [KW-1:0] k;
    logic          l;
    int            w;
    int            p0;
    int            q0;
    int            idx;
    int            exp_cnt;
    int            budget;
    logic          held_valid;
    logic [KW-1:0] held_key;
    logic [KW-1:0] exp5 [5];
    logic [KW-1:0] exp4 [4];

    exp5[0] = 32'd1; exp5[1] = 32'd3; exp5[2] = 32'd5; exp5[3] = 32'd7; exp5[4] = 32'd9;
    exp4[0] = 32'd10; exp4[1] = 32'd20; exp4[2] = 32'd30; exp4[3] = 32'd40;
    force_key[0] = 32'd8;
    force_key[1] = 32'd4;

    // ---- reset state ----
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_key", out_key, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_cmd_valid", {31'd0, hq_cmd_valid}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_order_err", {31'd0, order_err}, 32'd0);

    // ---- batch 5,3,9,1,7 ----
    $display("[TB] batch of five keys");
    applyStimulus(32'd5, 1'b0);
    checkOutput("fill_busy", {31'd0, busy}, 32'd1);
    applyStimulus(32'd3, 1'b0);
    applyStimulus(32'd9, 1'b0);
    applyStimulus(32'd1, 1'b0);
    applyStimulus(32'd7, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("b5_count_full", 32'(count), 32'd5);
    checkOutput("b5_in_ready_stall", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      getOutput(k, l, w);
      checkOutput("b5_key", k, exp5[i]);
      checkOutput("b5_last", {31'd0, l}, (i == 4) ? 32'd1 : 32'd0);
      checkOutput("b5_pop_latency", 32'(w), 32'd3);
    end
    checkOutput("b5_count_end", 32'(count), 32'd0);
    checkOutput("b5_busy_end", {31'd0, busy}, 32'd0);

    // ---- single key batch ----
    $display("[TB] single key batch");
    p0 = push_cnt;
    q0 = pop_cnt;
    applyStimulus(32'd42, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    getOutput(k, l, w);
    checkOutput("one_key", k, 32'd42);
    checkOutput("one_last", {31'd0, l}, 32'd1);
    checkOutput("one_pushes", 32'(push_cnt - p0), 32'd1);
    checkOutput("one_pops", 32'(pop_cnt - q0), 32'd1);
    checkOutput("one_busy_end", {31'd0, busy}, 32'd0);

    // ---- overflow: 16 keys without in_last, 17th stalls ----
    $display("[TB] overflow batch");
    p0 = push_cnt;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(32'(100 + ((i * 5) % 16)), 1'b0);
      if (i == 14) checkOutput("ovf_before", {31'd0, overflow}, 32'd0);
    end
    checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
    in_valid = 1'b1;
    in_key   = 32'd200;
    in_last  = 1'b1;
    checkOutput("ovf_17_stall", {31'd0, in_ready}, 32'd0);
    for (int j = 0; j < 16; j++) begin
      getOutput(k, l, w);
      checkOutput("ovf_key", k, 32'(100 + j));
      checkOutput("ovf_last", {31'd0, l}, (j == 15) ? 32'd1 : 32'd0);
      if (j < 15) checkOutput("ovf_17_held", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("ovf_pushes", 32'(push_cnt - p0), 32'd16);
    checkOutput("ovf_idle_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(32'd200, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    getOutput(k, l, w);
    checkOutput("ovf_17_key", k, 32'd200);
    checkOutput("ovf_17_last", {31'd0, l}, 32'd1);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

    // ---- random out_ready stalls ----
    $display("[TB] stalled output batch");
    applyStimulus(32'd30, 1'b0);
    applyStimulus(32'd10, 1'b0);
    applyStimulus(32'd40, 1'b0);
    applyStimulus(32'd20, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    idx = 0;
    exp_cnt = 4;
    budget = 400;
    held_valid = 1'b0;
    held_key = '0;
    while (idx < 4 && budget > 0) begin
      out_ready = 1'($urandom_range(0, 1));
      checkOutput("stall_count", 32'(count), 32'(exp_cnt));
      if (held_valid) begin
        checkOutput("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_key_hold", out_key, held_key);
      end
      held_valid = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          checkOutput("stall_key", out_key, exp4[idx]);
          checkOutput("stall_last", {31'd0, out_last}, (idx == 3) ? 32'd1 : 32'd0);
          idx++;
          exp_cnt--;
        end else begin
          held_valid = 1'b1;
          held_key   = out_key;
        end
      end
      tick();
      budget--;
    end
    out_ready = 1'b1;
    checkOutput("stall_all_out", 32'(idx), 32'd4);
    checkOutput("stall_count_end", 32'(count), 32'd0);
    checkOutput("stall_busy_end", {31'd0, busy}, 32'd0);

    // ---- heap returns 8 then 4 ----
    $display("[TB] out-of-order heap responses");
    force_n = 2;
    applyStimulus(32'd4, 1'b0);
    applyStimulus(32'd8, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    getOutput(k, l, w);
    checkOutput("ord_first", k, 32'd8);
    checkOutput("ord_clean", {31'd0, order_err}, 32'd0);
    getOutput(k, l, w);
    checkOutput("ord_second", k, 32'd4);
    checkOutput("ord_set", {31'd0, order_err}, 32'd1);
    applyStimulus(32'd77, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    getOutput(k, l, w);
    checkOutput("ord_next_key", k, 32'd77);
    checkOutput("ord_sticky", {31'd0, order_err}, 32'd1);

    // ---- reset while waiting on a pop response ----
    $display("[TB] reset mid-batch");
    rsp_lat = 50;
    applyStimulus(32'd11, 1'b0);
    applyStimulus(32'd22, 1'b0);
    applyStimulus(32'd33, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    checkOutput("mid_state_wait", 32'(dut.state), 32'(WAIT));
    checkOutput("mid_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_lat = 2;
    checkOutput("mid_state_idle", 32'(dut.state), 32'(IDLE));
    checkOutput("mid_count_clr", 32'(count), 32'd0);
    checkOutput("mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_overflow_clr", {31'd0, overflow}, 32'd0);
    checkOutput("mid_order_err_clr", {31'd0, order_err}, 32'd0);
    stray_req = stray_req + 1;
    tick();
    tick();
    tick();
    checkOutput("stray_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("stray_busy", {31'd0, busy}, 32'd0);
    checkOutput("stray_out_key", out_key, 32'd0);

    // ---- recovery batch after reset ----
    applyStimulus(32'd6, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    getOutput(k, l, w);
    checkOutput("post_rst_key", k, 32'd6);
    checkOutput("post_rst_last", {31'd0, l}, 32'd1);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
